mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Shares the single-port data/instruction RAM between the instruction-fetch port and the load/store port of the core, and owns the memory-mapped I/O window at the top of the address space. Each cycle it grants one requester, drives the synchronous RAM, and steers reads and writes to RAM or to the MMIO registers (seg0, seg1, switch input). It returns read data one cycle after the grant. It sits between the core pipeline and the memory/IO datapath and replaces ad-hoc address-decode selection with a registered, arbitrated bus.

## Interface
- addr_width, 10, word address width for both ports and the RAM
- data_width, 32, data word width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  addr_width  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch data valid (one cycle after i_gnt)
- i_rdata  out  data_width  fetch data; 0 when i_rvalid low
- d_req  in  1  load/store request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  addr_width  load/store address
- d_wdata  in  data_width  store data
- d_gnt  out  1  load/store accepted this cycle
- d_rvalid  out  1  load data valid (one cycle after a load grant; never for stores)
- d_rdata  out  data_width  load data; 0 when d_rvalid low
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  addr_width  RAM address
- mem_wdata  out  data_width  RAM write data
- mem_rdata  in  data_width  RAM read data, valid the cycle after mem_en with mem_we low
- sw_in  in  data_width  physical switch inputs
- seg0  out  data_width  display register 0
- seg1  out  data_width  display register 1

## Operation
- Arbitration: combinational grant from i_req, d_req, and the last_winner register. Only one requester: it wins. Both: the port that is not last_winner wins. last_winner updates on every grant. After reset last_winner = data, so the first conflict goes to fetch.
- At most one grant per cycle. The losing requester keeps req high and is granted next cycle. Two requesters can never wait more than 1 cycle.
- MMIO decode applies to the data port only, at full addr_width. Store to 0x3FF: seg0 <= d_wdata at the grant edge. Store to 0x3FE: seg1 <= d_wdata. Load from 0x3EF: returns sw_in sampled at the grant edge. For all three, mem_en = 0.
- Every other data-port address, and every fetch address including 0x3EF/0x3FE/0x3FF, goes to RAM: mem_en = 1, mem_we = d_we (0 for fetch), mem_addr/mem_wdata taken from the winner.
- Response stage registers: resp_valid, resp_port, resp_src (RAM or switch), sw_q. In the cycle after a read grant, only the matching rvalid is asserted, with rdata = mem_rdata or sw_q.
- Loads from unmapped MMIO addresses (for example 0x3F0) are ordinary RAM accesses.

## Timing
- Grant cycle N (req and gnt both high). Read data and rvalid arrive in cycle N+1. Store effects (RAM write or seg update) are visible from cycle N+1.
- Back-to-back grants are allowed every cycle. Full throughput is one access per cycle.
- Reset values: i_gnt = d_gnt = 0, i_rvalid = d_rvalid = 0, i_rdata = d_rdata = 0, mem_en = mem_we = 0, mem_addr = mem_wdata = 0, seg0 = seg1 = 0, last_winner = data, resp_valid = 0.
- While rst is high, grants are forced to 0 and no RAM or MMIO access occurs.
- Reset in the cycle after a read grant: the pending response is dropped and rvalid stays 0.
- Requests withdrawn before grant are legal and leave no state.

## Structure
- Package mem_bus_pkg: MMIO_SEG0_ADDR = 10'h3FF, MMIO_SEG1_ADDR = 10'h3FE, MMIO_SW_ADDR = 10'h3EF, enum port_t {PORT_I, PORT_D}, enum src_t {SRC_RAM, SRC_SW}.
- Sub-module mem_rr_arbiter: 2-way round-robin with inputs req[1:0], clk, rst and outputs gnt[1:0] plus the last_winner register. The top level holds the decode, the MMIO registers, and the response stage.

## Test plan
- Reset, then i_req alone at 0x010 with RAM[0x010] = 0xDEADBEEF: i_gnt in cycle N; i_rvalid = 1 and i_rdata = 0xDEADBEEF in N+1; d_rvalid = 0.
- i_req and d_req load both high for 4 cycles: grants alternate I, D, I, D. Each rvalid follows on its own port exactly one cycle later.
- Store 0x0000_0042 to 0x3FF, then 0x0000_0007 to 0x3FE: seg0 = 0x42 and seg1 = 0x07 from the cycle after each grant; mem_en = 0 in both grant cycles.
- With sw_in = 0x0000_00A5, load from 0x3EF: d_rdata = 0xA5 one cycle later and mem_en = 0. A fetch from 0x3EF instead reads RAM.
- Store 0x1234 to 0x020, then load from 0x020 on the next cycle: the load returns 0x1234.
- Assert rst in the cycle after a load grant: d_rvalid stays 0; all outputs return to their reset values; seg0 = seg1 = 0.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared constants and types for the memory bus arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_bus_pkg;

  // MMIO window at the top of the data-port address space
  localparam logic [9:0] MMIO_SEG0_ADDR = 10'h3FF;
  localparam logic [9:0] MMIO_SEG1_ADDR = 10'h3FE;
  localparam logic [9:0] MMIO_SW_ADDR   = 10'h3EF;

  // Enum value doubles as the bit index in the arbiter req/gnt vectors
  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  typedef enum logic {
    SRC_RAM = 1'b0,
    SRC_SW  = 1'b1
  } src_t;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin arbiter between fetch (bit 0) and load/store (bit 1).
// Latency: combinational grant in the request cycle; last_winner updates at that edge.
// Backpressure: the loser keeps requesting and is granted next cycle.
// Ports: clk, rst (sync, active-high), req[1:0] in, gnt[1:0] out (one-hot or zero),
//        last_winner out (port granted most recently, PORT_D after reset).
module mem_rr_arbiter
  import mem_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output port_t      last_winner
);

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // Conflict: the port that did not win last time goes first
        2'b11:   gnt = (last_winner == PORT_D) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner <= PORT_D;
    end else if (gnt[PORT_I]) begin
      last_winner <= PORT_I;
    end else if (gnt[PORT_D]) begin
      last_winner <= PORT_D;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates fetch and load/store onto a single-port sync RAM and owns the MMIO window.
// Latency: grant and RAM drive in cycle N; read data and rvalid in cycle N+1.
// Backpressure: a requester holds req until gnt; the loser waits at most one cycle.
// Ports: clk, rst; i_req/i_addr -> i_gnt, i_rvalid/i_rdata; d_req/d_we/d_addr/d_wdata ->
//        d_gnt, d_rvalid/d_rdata; mem_en/mem_we/mem_addr/mem_wdata -> RAM, mem_rdata <- RAM;
//        sw_in switch inputs; seg0/seg1 display registers.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int addr_width = 10,
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [addr_width-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [data_width-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [addr_width-1:0] d_addr,
  input  logic [data_width-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [data_width-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [addr_width-1:0] mem_addr,
  output logic [data_width-1:0] mem_wdata,
  input  logic [data_width-1:0] mem_rdata,
  input  logic [data_width-1:0] sw_in,
  output logic [data_width-1:0] seg0,
  output logic [data_width-1:0] seg1
);

  logic [1:0] gnt;
  port_t      last_winner;

  mem_rr_arbiter u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         ({d_req, i_req}),
    .gnt         (gnt),
    .last_winner (last_winner)
  );

  assign i_gnt = gnt[PORT_I];
  assign d_gnt = gnt[PORT_D];

  // MMIO decode is data-port only; each register responds to one direction,
  // the opposite direction at the same address falls through to RAM.
  logic seg0_st, seg1_st, sw_ld, d_mmio;
  assign seg0_st = d_we  && (d_addr == addr_width'(MMIO_SEG0_ADDR));
  assign seg1_st = d_we  && (d_addr == addr_width'(MMIO_SEG1_ADDR));
  assign sw_ld   = !d_we && (d_addr == addr_width'(MMIO_SW_ADDR));
  assign d_mmio  = seg0_st || seg1_st || sw_ld;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (i_gnt) begin
      mem_en   = 1'b1;
      mem_addr = i_addr;
    end else if (d_gnt && !d_mmio) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  logic                  resp_valid;
  port_t                 resp_port;
  src_t                  resp_src;
  logic [data_width-1:0] sw_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg0       <= '0;
      seg1       <= '0;
      resp_valid <= 1'b0;
      resp_port  <= PORT_I;
      resp_src   <= SRC_RAM;
      sw_q       <= '0;
    end else begin
      if (d_gnt && seg0_st) seg0 <= d_wdata;
      if (d_gnt && seg1_st) seg1 <= d_wdata;
      if (d_gnt && sw_ld)   sw_q <= sw_in;
      resp_valid <= i_gnt || (d_gnt && !d_we);
      resp_port  <= d_gnt ? PORT_D : PORT_I;
      resp_src   <= (d_gnt && sw_ld) ? SRC_SW : SRC_RAM;
    end
  end

  // rst masks the response immediately so a read granted just before reset
  // never surfaces, even though resp_valid only clears at the next edge.
  logic                  resp_live;
  logic [data_width-1:0] resp_data;
  assign resp_live = resp_valid && !rst;
  assign resp_data = (resp_src == SRC_SW) ? sw_q : mem_rdata;

  assign i_rvalid = resp_live && (resp_port == PORT_I);
  assign d_rvalid = resp_live && (resp_port == PORT_D);
  assign i_rdata  = i_rvalid ? resp_data : '0;
  assign d_rdata  = d_rvalid ? resp_data : '0;

endmodule
